// File: rtl/v_list_dump_if.sv
// v_list_dump_if: shared list-query types plus the request, query, entry and done bundle of the list-dump initiator
//   v_pkg        : id_t, level_t, key_t, size_t, listsize_t
//   master       : the initiator's view (v_list_dump)
//   slave        : the surrounding environment's view (request source, table responder, entry consumer)
package v_pkg;
    typedef logic [7:0]  id_t;
    typedef logic [3:0]  level_t;
    typedef logic [15:0] key_t;
    typedef logic [15:0] size_t;
    typedef logic [7:0]  listsize_t;
endpackage

interface v_list_dump_if;
    import v_pkg::*;
    logic      i_busy;
    logic      i_dump_vld;
    id_t       i_dump_prod_id;
    logic      o_dump_rdy;
    logic      o_lut_vld;
    id_t       o_lut_prod_id;
    level_t    o_lut_level;
    key_t      i_lut_key;
    size_t     i_lut_size;
    logic      i_lut_error;
    listsize_t i_lut_listsize;
    logic      o_ent_vld_r;
    level_t    o_ent_level_r;
    key_t      o_ent_key_r;
    size_t     o_ent_size_r;
    logic      i_ent_rdy;
    logic      o_done_r;
    listsize_t o_done_listsize_r;
    logic      o_done_error_r;
    logic      o_done_trunc_r;
    modport master (
        input  i_busy, i_dump_vld, i_dump_prod_id, i_lut_key, i_lut_size, i_lut_error, i_lut_listsize, i_ent_rdy,
        output o_dump_rdy, o_lut_vld, o_lut_prod_id, o_lut_level, o_ent_vld_r, o_ent_level_r, o_ent_key_r,
               o_ent_size_r, o_done_r, o_done_listsize_r, o_done_error_r, o_done_trunc_r
    );
    modport slave (
        output i_busy, i_dump_vld, i_dump_prod_id, i_lut_key, i_lut_size, i_lut_error, i_lut_listsize, i_ent_rdy,
        input  o_dump_rdy, o_lut_vld, o_lut_prod_id, o_lut_level, o_ent_vld_r, o_ent_level_r, o_ent_key_r,
               o_ent_size_r, o_done_r, o_done_listsize_r, o_done_error_r, o_done_trunc_r
    );
endinterface

// File: rtl/v_list_dump.sv
// v_list_dump: walks one product's list level by level over the query bus and streams entries through a FWFT FIFO
//   clk, rst : clock, synchronous active-high reset
//   bus      : request (i_busy/i_dump_*/o_dump_rdy), query (o_lut_*/i_lut_*), entry stream (o_ent_*/i_ent_rdy),
//              completion (o_done_*)
module v_list_dump #(
    parameter int LUT_LATENCY = 2,
    parameter int LEVELS_N    = 16,
    parameter int DEPTH       = 4
) (
    input logic           clk,
    input logic           rst,
    v_list_dump_if.master bus
);
    import v_pkg::*;
    localparam int LSW = $bits(listsize_t);
    localparam int LVW = $bits(level_t);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + LUT_LATENCY + 1);
    typedef enum logic [2:0] {IDLE, PROBE, WAIT_SZ, SWEEP, DRAIN} state_t;
    state_t                 state, state_nxt;
    id_t                    prod_r, lut_prod_q;
    level_t                 level_r, lut_lvl_q, q_lvl;
    listsize_t              listsize_r, n_r, rsp_n;
    logic                   err_r, trunc_r;
    logic [LUT_LATENCY-1:0] pipe_vld;
    level_t                 pipe_lvl [LUT_LATENCY];
    level_t                 mem_lvl  [DEPTH];
    key_t                   mem_key  [DEPTH];
    size_t                  mem_size [DEPTH];
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [CW-1:0]          count, inflight;
    logic                   accept, issue, credit, last_lvl, drained, lut_vld, rsp_vld, push, pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    // Responses still in the latency pipe count against FIFO space, so a query is only
    // issued once its eventual entry is guaranteed a slot.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LUT_LATENCY; i++) inflight = inflight + CW'(pipe_vld[i]);
    end

    assign rsp_vld  = pipe_vld[LUT_LATENCY-1];
    assign rsp_n    = bus.i_lut_listsize > LSW'(LEVELS_N) ? LSW'(LEVELS_N) : bus.i_lut_listsize;
    assign credit   = (count + inflight) < CW'(DEPTH);
    assign last_lvl = LSW'(level_r) == n_r - LSW'(1);
    assign drained  = inflight == '0 && count == '0;
    assign accept   = bus.i_dump_vld & bus.o_dump_rdy;
    assign push     = rsp_vld & ~bus.i_lut_error;
    assign pop      = bus.o_ent_vld_r & bus.i_ent_rdy;
    assign lut_vld  = state == PROBE || issue;
    assign q_lvl    = state == PROBE ? '0 : level_r;

    always_ff @(posedge clk) state <= rst ? IDLE : state_nxt;

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            IDLE:    state_nxt = accept ? PROBE : IDLE;
            PROBE:   state_nxt = WAIT_SZ;
            WAIT_SZ: if (rsp_vld) state_nxt = (bus.i_lut_error || rsp_n <= LSW'(1)) ? DRAIN : SWEEP;
            SWEEP: begin
                issue     = credit;
                state_nxt = credit && last_lvl ? DRAIN : SWEEP;
            end
            DRAIN:   state_nxt = drained ? IDLE : DRAIN;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.o_dump_rdy        = state == IDLE && !bus.i_busy;
    assign bus.o_lut_vld         = lut_vld;
    assign bus.o_lut_level       = lut_vld ? q_lvl : lut_lvl_q;
    assign bus.o_lut_prod_id     = lut_vld ? prod_r : lut_prod_q;
    assign bus.o_ent_vld_r       = count != '0;
    assign bus.o_ent_level_r     = mem_lvl[rd_ptr];
    assign bus.o_ent_key_r       = mem_key[rd_ptr];
    assign bus.o_ent_size_r      = mem_size[rd_ptr];
    assign bus.o_done_r          = state == DRAIN && drained;
    assign bus.o_done_listsize_r = listsize_r;
    assign bus.o_done_error_r    = err_r;
    assign bus.o_done_trunc_r    = trunc_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_r     <= '0;
            lut_prod_q <= '0;
            lut_lvl_q  <= '0;
            level_r    <= '0;
            listsize_r <= '0;
            n_r        <= '0;
            err_r      <= 1'b0;
            trunc_r    <= 1'b0;
            pipe_vld   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            for (int i = 0; i < LUT_LATENCY; i++) pipe_lvl[i] <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_lvl[i]  <= '0;
                mem_key[i]  <= '0;
                mem_size[i] <= '0;
            end
        end else begin
            for (int i = 1; i < LUT_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_lvl[i] <= pipe_lvl[i-1];
            end
            pipe_vld[0] <= lut_vld;
            pipe_lvl[0] <= q_lvl;
            if (lut_vld) begin
                lut_prod_q <= prod_r;
                lut_lvl_q  <= q_lvl;
            end
            if (accept) prod_r <= bus.i_dump_prod_id;
            // Error is sticky for the dump: a shrinking list drops the response but is reported at done.
            if (accept) err_r <= 1'b0;
            else if (rsp_vld && bus.i_lut_error) err_r <= 1'b1;
            if (state == WAIT_SZ && rsp_vld) begin
                listsize_r <= bus.i_lut_listsize;
                n_r        <= rsp_n;
                trunc_r    <= bus.i_lut_listsize > LSW'(LEVELS_N);
                level_r    <= LVW'(1);
            end else if (issue) level_r <= level_r + LVW'(1);
            if (push) begin
                mem_lvl[wr_ptr]  <= pipe_lvl[LUT_LATENCY-1];
                mem_key[wr_ptr]  <= bus.i_lut_key;
                mem_size[wr_ptr] <= bus.i_lut_size;
                wr_ptr           <= inc(wr_ptr);
            end
            if (pop) rd_ptr <= inc(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_v_list_dump.sv
// tb_v_list_dump: directed scenarios against a behavioural list table with a 2-cycle query latency
module tb_v_list_dump;
    import v_pkg::*;
    localparam int L = 2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    always #5 clk = ~clk;

    v_list_dump_if bus();
    v_list_dump #(.LUT_LATENCY(L), .LEVELS_N(16), .DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Table responder: levels at or beyond the listsize, or at or beyond the shrink point, answer with error.
    int     m_listsize = 0;
    int     m_shrink   = 255;
    logic [1:0] m_vld  = '0;
    level_t m_lvl [2];
    id_t    m_prod [2];
    always @(posedge clk) begin
        m_vld     <= {m_vld[0], bus.o_lut_vld};
        m_lvl[1]  <= m_lvl[0];
        m_lvl[0]  <= bus.o_lut_level;
        m_prod[1] <= m_prod[0];
        m_prod[0] <= bus.o_lut_prod_id;
    end

    function automatic key_t exp_key(input id_t p, input int lvl);
        return 16'h1000 + 16'(lvl * 17) + 16'(p);
    endfunction
    function automatic size_t exp_size(input int lvl);
        return 16'h0100 + 16'(lvl);
    endfunction

    assign bus.i_lut_key      = exp_key(m_prod[1], int'(m_lvl[1]));
    assign bus.i_lut_size     = exp_size(int'(m_lvl[1]));
    assign bus.i_lut_error    = m_vld[1] && (int'(m_lvl[1]) >= m_listsize || int'(m_lvl[1]) >= m_shrink);
    assign bus.i_lut_listsize = listsize_t'(m_listsize);

    level_t    got_lvl [$];
    key_t      got_key [$];
    size_t     got_size [$];
    int        first_k, done_k, issued, max_out, rdy_during;
    logic      done_seen, d_err, d_trunc;
    listsize_t d_ls;

    // Drives one request (accepted at k=0) and samples every cycle until done or the cycle budget runs out.
    task automatic run_dump(input id_t prod, input int ls, input int shrink, input bit bp, input bit hold,
                            output bit acc);
        int popped;
        popped = 0;
        m_listsize = ls;
        m_shrink = shrink;
        got_lvl.delete();
        got_key.delete();
        got_size.delete();
        first_k = -1;
        done_k = -1;
        issued = 0;
        max_out = 0;
        rdy_during = 0;
        done_seen = 1'b0;
        @(posedge clk); #1;
        bus.i_dump_vld = 1'b1;
        bus.i_dump_prod_id = prod;
        bus.i_ent_rdy = !bp;
        @(negedge clk);
        acc = bus.o_dump_rdy;
        for (int k = 1; k < 300 && !done_seen; k++) begin
            @(posedge clk); #1;
            bus.i_dump_vld = hold;
            if (bp) bus.i_ent_rdy = ((k / 3) % 2) == 1;
            @(negedge clk);
            if (bus.o_dump_rdy) rdy_during++;
            if (bus.o_lut_vld) issued++;
            if (bus.o_ent_vld_r && bus.i_ent_rdy) begin
                got_lvl.push_back(bus.o_ent_level_r);
                got_key.push_back(bus.o_ent_key_r);
                got_size.push_back(bus.o_ent_size_r);
                popped++;
                if (first_k < 0) first_k = k;
            end
            if (issued - popped > max_out) max_out = issued - popped;
            if (bus.o_done_r) begin
                done_seen = 1'b1;
                done_k = k;
                d_ls = bus.o_done_listsize_r;
                d_err = bus.o_done_error_r;
                d_trunc = bus.o_done_trunc_r;
            end
        end
        @(posedge clk); #1;
        bus.i_dump_vld = 1'b0;
        bus.i_ent_rdy = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.o_lut_vld !== 1'b0) begin errors++; $display("FAIL reset_lut_vld: got %b want 0", bus.o_lut_vld); end
        checks++; if (bus.o_ent_vld_r !== 1'b0) begin errors++; $display("FAIL reset_ent_vld: got %b want 0", bus.o_ent_vld_r); end
        checks++; if (bus.o_done_r !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.o_done_r); end
        checks++; if ({bus.o_done_listsize_r, bus.o_done_error_r, bus.o_done_trunc_r} !== 10'd0) begin errors++; $display("FAIL reset_done_status: got %h/%b/%b want 0/0/0", bus.o_done_listsize_r, bus.o_done_error_r, bus.o_done_trunc_r); end
        checks++; if ({bus.o_lut_level, bus.o_lut_prod_id} !== 12'd0) begin errors++; $display("FAIL reset_lut_addr: got level %h prod %h want 0/0", bus.o_lut_level, bus.o_lut_prod_id); end
        checks++; if (bus.o_dump_rdy !== 1'b1) begin errors++; $display("FAIL reset_dump_rdy: got %b want 1", bus.o_dump_rdy); end
    endtask

    task automatic test_basic;
        bit acc;
        run_dump(8'h21, 3, 255, 1'b0, 1'b0, acc);
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL basic_accept: got %b want 1", acc); end
        checks++; if (got_lvl.size() != 3) begin errors++; $display("FAIL basic_count: got %0d want 3", got_lvl.size()); end
        for (int i = 0; i < got_lvl.size(); i++) begin
            checks++; if (got_lvl[i] !== level_t'(i)) begin errors++; $display("FAIL basic_level[%0d]: got %0d want %0d", i, got_lvl[i], i); end
            checks++; if (got_key[i] !== exp_key(8'h21, i) || got_size[i] !== exp_size(i)) begin errors++; $display("FAIL basic_data[%0d]: got %h/%h want %h/%h", i, got_key[i], got_size[i], exp_key(8'h21, i), exp_size(i)); end
        end
        checks++; if (first_k != 4) begin errors++; $display("FAIL basic_first_entry: got T+%0d want T+4", first_k); end
        checks++; if (done_k != 9) begin errors++; $display("FAIL basic_done_time: got T+%0d want T+9", done_k); end
        checks++; if ({d_ls, d_err, d_trunc} !== {8'd3, 1'b0, 1'b0}) begin errors++; $display("FAIL basic_done_status: got %0d/%b/%b want 3/0/0", d_ls, d_err, d_trunc); end
    endtask

    task automatic test_empty;
        bit acc;
        run_dump(8'h05, 0, 255, 1'b0, 1'b0, acc);
        checks++; if (got_lvl.size() != 0) begin errors++; $display("FAIL empty_count: got %0d want 0", got_lvl.size()); end
        checks++; if (done_k != 4) begin errors++; $display("FAIL empty_done_time: got T+%0d want T+4", done_k); end
        checks++; if ({d_ls, d_err, d_trunc} !== {8'd0, 1'b1, 1'b0}) begin errors++; $display("FAIL empty_done_status: got %0d/%b/%b want 0/1/0", d_ls, d_err, d_trunc); end
        checks++; if (issued != 1) begin errors++; $display("FAIL empty_queries: got %0d want 1", issued); end
    endtask

    task automatic test_trunc;
        bit acc;
        run_dump(8'h33, 20, 255, 1'b0, 1'b0, acc);
        checks++; if (got_lvl.size() != 16) begin errors++; $display("FAIL trunc_count: got %0d want 16", got_lvl.size()); end
        for (int i = 0; i < got_lvl.size(); i++) begin
            checks++; if (got_lvl[i] !== level_t'(i) || got_key[i] !== exp_key(8'h33, i)) begin errors++; $display("FAIL trunc_entry[%0d]: got %0d/%h want %0d/%h", i, got_lvl[i], got_key[i], i, exp_key(8'h33, i)); end
        end
        checks++; if ({d_ls, d_err, d_trunc} !== {8'd20, 1'b0, 1'b1}) begin errors++; $display("FAIL trunc_done_status: got %0d/%b/%b want 20/0/1", d_ls, d_err, d_trunc); end
        checks++; if (issued != 16) begin errors++; $display("FAIL trunc_queries: got %0d want 16", issued); end
    endtask

    task automatic test_backpressure;
        bit acc;
        run_dump(8'h44, 8, 255, 1'b1, 1'b0, acc);
        checks++; if (got_lvl.size() != 8) begin errors++; $display("FAIL bp_count: got %0d want 8", got_lvl.size()); end
        for (int i = 0; i < got_lvl.size(); i++) begin
            checks++; if (got_lvl[i] !== level_t'(i) || got_key[i] !== exp_key(8'h44, i) || got_size[i] !== exp_size(i)) begin errors++; $display("FAIL bp_entry[%0d]: got %0d/%h/%h want %0d/%h/%h", i, got_lvl[i], got_key[i], got_size[i], i, exp_key(8'h44, i), exp_size(i)); end
        end
        checks++; if (max_out > 4) begin errors++; $display("FAIL bp_credit: got outstanding %0d want <=4", max_out); end
        checks++; if (issued != 8) begin errors++; $display("FAIL bp_queries: got %0d want 8", issued); end
        checks++; if (!done_seen || d_err !== 1'b0) begin errors++; $display("FAIL bp_done: got seen %b err %b want 1/0", done_seen, d_err); end
    endtask

    task automatic test_shrink;
        bit acc;
        run_dump(8'h55, 8, 5, 1'b0, 1'b0, acc);
        checks++; if (got_lvl.size() != 5) begin errors++; $display("FAIL shrink_count: got %0d want 5", got_lvl.size()); end
        for (int i = 0; i < got_lvl.size(); i++) begin
            checks++; if (got_lvl[i] !== level_t'(i) || got_key[i] !== exp_key(8'h55, i)) begin errors++; $display("FAIL shrink_entry[%0d]: got %0d/%h want %0d/%h", i, got_lvl[i], got_key[i], i, exp_key(8'h55, i)); end
        end
        checks++; if ({d_ls, d_err, d_trunc} !== {8'd8, 1'b1, 1'b0}) begin errors++; $display("FAIL shrink_done_status: got %0d/%b/%b want 8/1/0", d_ls, d_err, d_trunc); end
        checks++; if (issued != 8) begin errors++; $display("FAIL shrink_queries: got %0d want 8", issued); end
    endtask

    task automatic test_reset_mid;
        int bad;
        bad = 0;
        m_listsize = 12;
        m_shrink = 255;
        @(posedge clk); #1;
        bus.i_dump_vld = 1'b1;
        bus.i_dump_prod_id = 8'h9A;
        @(posedge clk); #1;
        bus.i_dump_vld = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if ({bus.o_lut_vld, bus.o_ent_vld_r, bus.o_done_r} !== 3'b000) begin errors++; $display("FAIL midrst_valids: got lut %b ent %b done %b want 000", bus.o_lut_vld, bus.o_ent_vld_r, bus.o_done_r); end
        checks++; if ({bus.o_lut_level, bus.o_lut_prod_id, bus.o_ent_key_r} !== 28'd0) begin errors++; $display("FAIL midrst_data: got level %h prod %h key %h want 0", bus.o_lut_level, bus.o_lut_prod_id, bus.o_ent_key_r); end
        @(posedge clk); #1 rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.o_ent_vld_r || bus.o_done_r || bus.o_lut_vld) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL midrst_stale: got %0d active cycles want 0", bad); end
    endtask

    task automatic test_busy;
        int bad;
        bad = 0;
        @(posedge clk); #1;
        bus.i_busy = 1'b1;
        bus.i_dump_vld = 1'b1;
        bus.i_dump_prod_id = 8'h11;
        repeat (6) begin
            @(negedge clk);
            if (bus.o_dump_rdy || bus.o_lut_vld) bad++;
            @(posedge clk); #1;
        end
        bus.i_dump_vld = 1'b0;
        bus.i_busy = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.o_lut_vld) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL busy_block: got %0d active cycles want 0", bad); end
    endtask

    task automatic test_back_to_back;
        bit acc;
        run_dump(8'h66, 2, 255, 1'b0, 1'b1, acc);
        checks++; if (acc !== 1'b1 || got_lvl.size() != 2 || !done_seen) begin errors++; $display("FAIL b2b_first: got acc %b count %0d done %b want 1/2/1", acc, got_lvl.size(), done_seen); end
        checks++; if (rdy_during != 0) begin errors++; $display("FAIL b2b_rdy_during: got %0d ready cycles want 0", rdy_during); end
        @(negedge clk);
        checks++; if (bus.o_dump_rdy !== 1'b1) begin errors++; $display("FAIL b2b_rdy_after: got %b want 1", bus.o_dump_rdy); end
        run_dump(8'h77, 1, 255, 1'b0, 1'b0, acc);
        checks++; if (got_lvl.size() != 1 || got_key[0] !== exp_key(8'h77, 0)) begin errors++; $display("FAIL b2b_single: got count %0d want 1 with key %h", got_lvl.size(), exp_key(8'h77, 0)); end
        checks++; if (done_k != 5 || d_err !== 1'b0 || d_ls !== 8'd1) begin errors++; $display("FAIL b2b_single_done: got T+%0d err %b ls %0d want T+5/0/1", done_k, d_err, d_ls); end
    endtask

    initial begin
        bus.i_busy = 1'b0;
        bus.i_dump_vld = 1'b0;
        bus.i_dump_prod_id = '0;
        bus.i_ent_rdy = 1'b1;
        test_reset();
        test_basic();
        test_empty();
        test_trunc();
        test_backpressure();
        test_shrink();
        test_reset_mid();
        test_busy();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
